wavelet_frame_scheduler: RTL and testbench
==========================================

# wavelet_frame_scheduler

Frame-level sequencer for the 2-D wavelet transform engine. It keeps the engine in reset between frames, gates the upstream pixel stream into the engine's 16-bit input, and owns the single port of the 4096×16 coefficient RAM. After the transform signals completion, it streams all 4096 coefficients out over a ready/valid interface and pulses `frame_done`. It sits between the pixel source, the transform engine and the downstream coefficient coder.

## Interface
Parameters:
- `DATA_W`, 16, sample/coefficient width
- `ADDR_W`, 12, coefficient RAM address width
- `N_WORDS`, 4096, coefficients per frame (64×64)
- `RST_HOLD`, 3, cycles the engine reset is held in CLEAR (≥1)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock
- `rst_n`  in  1  async active-low reset
- `frame_start`  in  1  one-cycle start request
- `busy`  out  1  high in every state except IDLE
- `frame_done`  out  1  one-cycle pulse after the last coefficient is accepted
- `underrun`  out  1  sticky; engine requested a pixel while `src_valid`=0; cleared by `frame_start` in IDLE
- `src_valid`  in  1  upstream pixel valid
- `src_data`  in  DATA_W  upstream pixel
- `src_ready`  out  1  pixel consumed this cycle
- `wt_rst_n`  out  1  engine reset, active-low
- `wt_data_input`  out  DATA_W  pixel to engine
- `wt_data_in_ready`  in  1  engine consumes `wt_data_input` this cycle
- `wt_end_flag`  in  1  engine finished (level)
- `wt_ram_address`  in  ADDR_W  engine RAM address
- `wt_ram_data`  in  DATA_W  engine write data
- `wt_ram_wren`  in  1  engine write enable
- `wt_ram_qout`  out  DATA_W  RAM read data to engine (equal to `ram_q`)
- `ram_address`  out  ADDR_W  RAM port address
- `ram_data`  out  DATA_W  RAM port write data
- `ram_wren`  out  1  RAM port write enable
- `ram_q`  in  DATA_W  RAM read data, registered, 1-cycle latency
- `coef_valid`  out  1  coefficient valid
- `coef_data`  out  DATA_W  coefficient
- `coef_last`  out  1  marks address N_WORDS-1
- `coef_ready`  in  1  downstream accepts

## Operation
- States: IDLE → CLEAR → TRANSFORM → DRAIN → DONE → IDLE.
- IDLE: `wt_rst_n`=0. On `frame_start`=1: clear `underrun` and go to CLEAR.
- CLEAR: `wt_rst_n`=0 for exactly RST_HOLD cycles, counted by the hold counter, then go to TRANSFORM.
- TRANSFORM:
  - `wt_rst_n`=1.
  - `wt_data_input`=`src_data`; `src_ready`=`wt_data_in_ready`.
  - If `wt_data_in_ready`=1 and `src_valid`=0, set `underrun`. The engine cannot stall, so the stale data is consumed anyway.
  - RAM port follows the engine: `ram_address`/`ram_data`/`ram_wren` = `wt_ram_*`.
  - When `wt_end_flag`=1, go to DRAIN and reset the read counter to 0.
- DRAIN:
  - `wt_rst_n`=0 and `ram_wren`=0; `ram_address` = read counter.
  - Issue a read when (buffer occupancy + reads in flight) < 2 and the read counter ≤ N_WORDS-1; the counter then increments.
  - `ram_q` is captured into a 2-entry skid buffer one cycle after the read is issued.
  - Output is in linear address order 0..N_WORDS-1.
  - `coef_last` is set with the word read from address N_WORDS-1.
  - When the last word is accepted (`coef_valid & coef_ready & coef_last`), go to DONE.
- DONE: `frame_done`=1 for one cycle, then go to IDLE.
- `frame_start` is ignored whenever `busy`=1.
- Outside TRANSFORM: `src_ready`=0 and `wt_data_input`=0.
- Outside TRANSFORM and DRAIN: `ram_address`=0, `ram_data`=0, `ram_wren`=0.

## Timing
- Reset values:
  - `busy`=0, `frame_done`=0, `underrun`=0, `src_ready`=0, `wt_rst_n`=0.
  - `ram_address`=0, `ram_wren`=0, `ram_data`=0, `wt_data_input`=0.
  - `coef_valid`=0, `coef_data`=0, `coef_last`=0.
  - State = IDLE; all counters 0.
- `frame_start` at cycle t → `busy`=1 at t+1; `wt_rst_n` rises at t+1+RST_HOLD.
- `wt_end_flag` sampled high at cycle t → first read issued at t+1 → first `coef_valid` at t+3.
- With `coef_ready` held at 1, throughput is one word per cycle with no bubbles. DRAIN lasts N_WORDS+2 cycles.
- When `coef_ready`=0:
  - `coef_data`/`coef_last` hold stable.
  - The buffer absorbs the one in-flight read.
  - No words are lost or duplicated.
- Read counter is ADDR_W+1 bits so that N_WORDS is representable; it never wraps.
- Asynchronous `rst_n` mid-frame:
  - Returns to IDLE immediately; `wt_rst_n` goes low.
  - Skid buffer is flushed.
  - No `frame_done` pulse.
- `frame_start` arriving in the same cycle as DONE is ignored.

## Structure
- Package `wavelet_pkg`:
  - State enum (IDLE, CLEAR, TRANSFORM, DRAIN, DONE).
  - Constants DATA_W, ADDR_W, N_WORDS, RST_HOLD, shared with the transform engine.
- Sub-module `coef_skid_buffer`:
  - 2-entry ready/valid buffer carrying `{coef_last, data}`.
  - Exposes occupancy, used for read-issue gating.
  - Has a flush input.
- Top-level contents: FSM, hold counter, read counter, in-flight flag, RAM port mux.

## Test plan
- Nominal frame: `frame_start`, pixels 0..4095 always valid, engine model asserts `wt_end_flag`, `coef_ready`=1 → 4096 words in address order; `coef_last` only on word 4095; `frame_done` at exactly DRAIN entry + 4098; `underrun`=0.
- Backpressure: toggle `coef_ready` with a random 50% pattern → output sequence matches RAM contents exactly; data stable while stalled.
- Underrun: hold `src_valid`=0 for 3 cycles while `wt_data_in_ready`=1 → `underrun`=1 and stays set until the next `frame_start`.
- Start while busy: `frame_start` pulsed during TRANSFORM and in the DONE cycle → ignored; exactly one `frame_done`.
- Reset mid-DRAIN at word 100 → all outputs at reset values next cycle; a following frame delivers 4096 words starting at address 0.
- CLEAR timing: `frame_start` at cycle 10 → `wt_rst_n`=0 during cycles 11..13, =1 from cycle 14.

Source files
------------

// File: rtl/wavelet_pkg.sv
// Constants and state encoding shared by the frame scheduler and the transform engine.
package wavelet_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 12;
    localparam int N_WORDS  = 4096;
    localparam int RST_HOLD = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        TRANSFORM = 3'd2,
        DRAIN     = 3'd3,
        DONE      = 3'd4
    } state_e;

endpackage

// File: rtl/coef_skid_buffer.sv
// Two-entry ready/valid buffer for {last, coefficient} words read from the coefficient RAM.
module coef_skid_buffer
    import wavelet_pkg::*;
#(
    parameter int W = DATA_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   occupancy
);

    logic [1:0][W-1:0] entry_q, entry_d;
    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              push, pop;

    assign push      = in_valid;
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = entry_q[rd_ptr_q];
    assign occupancy = count_q;

    // The producer gates its reads on occupancy, so a push never lands on a full buffer.
    always_comb begin
        entry_d  = entry_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                entry_d[wr_ptr_q] = in_data;
                wr_ptr_d          = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q  <= '0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            entry_q  <= entry_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/wavelet_frame_scheduler.sv
// Frame sequencer: holds the wavelet engine in reset between frames, feeds it pixels,
// owns the coefficient RAM port and streams the finished frame out over ready/valid.
module wavelet_frame_scheduler
    import wavelet_pkg::*;
#(
    parameter int DATA_W   = wavelet_pkg::DATA_W,
    parameter int ADDR_W   = wavelet_pkg::ADDR_W,
    parameter int N_WORDS  = wavelet_pkg::N_WORDS,
    parameter int RST_HOLD = wavelet_pkg::RST_HOLD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              wt_rst_n,
    output logic [DATA_W-1:0] wt_data_input,
    input  logic              wt_data_in_ready,
    input  logic              wt_end_flag,
    input  logic [ADDR_W-1:0] wt_ram_address,
    input  logic [DATA_W-1:0] wt_ram_data,
    input  logic              wt_ram_wren,
    output logic [DATA_W-1:0] wt_ram_qout,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              coef_valid,
    output logic [DATA_W-1:0] coef_data,
    output logic              coef_last,
    input  logic              coef_ready
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic                inflight_q, inflight_d;
    logic                inflight_last_q, inflight_last_d;
    logic                underrun_q, underrun_d;

    logic                rd_issue;
    logic                buf_valid;
    logic                buf_pop;
    logic [DATA_W:0]     buf_word;
    logic [1:0]          buf_occ;
    logic [2:0]          slots_used;

    assign wt_ram_qout = ram_q;
    assign underrun    = underrun_q;

    // A word leaving the buffer this cycle frees its slot now, which keeps the
    // stream gap-free at one word per cycle with only two entries of storage.
    assign buf_pop    = buf_valid & coef_ready;
    assign slots_used = 3'(buf_occ) + 3'(inflight_q) - 3'(buf_pop);
    assign rd_issue   = (state_q == DRAIN) && (slots_used < 3'd2)
                        && (rd_cnt_q < CNT_W'(N_WORDS));

    assign inflight_d      = rd_issue;
    assign inflight_last_d = rd_issue && (rd_cnt_q == CNT_W'(N_WORDS - 1));

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        rd_cnt_d   = rd_cnt_q;
        underrun_d = underrun_q;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    underrun_d = 1'b0;
                    hold_d     = '0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
                    hold_d  = '0;
                    state_d = TRANSFORM;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            TRANSFORM: begin
                // The engine cannot stall, so a missing pixel is only flagged.
                if (wt_data_in_ready && !src_valid) begin
                    underrun_d = 1'b1;
                end
                if (wt_end_flag) begin
                    rd_cnt_d = '0;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_issue) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (coef_valid && coef_ready && coef_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            hold_q          <= '0;
            rd_cnt_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            underrun_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            rd_cnt_q        <= rd_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            underrun_q      <= underrun_d;
        end
    end

    // RAM port and engine-side muxing.
    always_comb begin
        busy          = (state_q != IDLE);
        frame_done    = (state_q == DONE);
        wt_rst_n      = (state_q == TRANSFORM);
        src_ready     = 1'b0;
        wt_data_input = '0;
        ram_address   = '0;
        ram_data      = '0;
        ram_wren      = 1'b0;
        case (state_q)
            TRANSFORM: begin
                src_ready     = wt_data_in_ready;
                wt_data_input = src_data;
                ram_address   = wt_ram_address;
                ram_data      = wt_ram_data;
                ram_wren      = wt_ram_wren;
            end
            DRAIN: begin
                ram_address = rd_cnt_q[ADDR_W-1:0];
            end
            default: begin
            end
        endcase
    end

    coef_skid_buffer #(
        .W (DATA_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (state_q == IDLE),
        .in_valid  (inflight_q),
        .in_data   ({inflight_last_q, ram_q}),
        .out_valid (buf_valid),
        .out_data  (buf_word),
        .out_ready (coef_ready),
        .occupancy (buf_occ)
    );

    assign coef_valid              = buf_valid;
    assign {coef_last, coef_data}  = buf_valid ? buf_word : '0;

endmodule

// File: tb/tb_wavelet_frame_scheduler.sv
// Directed bench for wavelet_frame_scheduler: engine/RAM model, coefficient monitor, scenario tasks.
module tb_wavelet_frame_scheduler;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int NW = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          busy, frame_done, underrun;
    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_ready;
    logic          wt_rst_n;
    logic [DW-1:0] wt_data_input;
    logic          wt_data_in_ready = 1'b0;
    logic          wt_end_flag = 1'b0;
    logic [AW-1:0] wt_ram_address = '0;
    logic [DW-1:0] wt_ram_data = '0;
    logic          wt_ram_wren = 1'b0;
    logic [DW-1:0] wt_ram_qout;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q = '0;
    logic          coef_valid;
    logic [DW-1:0] coef_data;
    logic          coef_last;
    logic          coef_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int end_cyc = 0;
    int pass_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wavelet_frame_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frame_start      (frame_start),
        .busy             (busy),
        .frame_done       (frame_done),
        .underrun         (underrun),
        .src_valid        (src_valid),
        .src_data         (src_data),
        .src_ready        (src_ready),
        .wt_rst_n         (wt_rst_n),
        .wt_data_input    (wt_data_input),
        .wt_data_in_ready (wt_data_in_ready),
        .wt_end_flag      (wt_end_flag),
        .wt_ram_address   (wt_ram_address),
        .wt_ram_data      (wt_ram_data),
        .wt_ram_wren      (wt_ram_wren),
        .wt_ram_qout      (wt_ram_qout),
        .ram_address      (ram_address),
        .ram_data         (ram_data),
        .ram_wren         (ram_wren),
        .ram_q            (ram_q),
        .coef_valid       (coef_valid),
        .coef_data        (coef_data),
        .coef_last        (coef_last),
        .coef_ready       (coef_ready)
    );

    // Coefficient RAM: single port, registered read.
    logic [DW-1:0] mem [NW];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    // Monitor: records accepted words, frame_done pulses and stall behaviour.
    logic [DW:0]   got [$];
    int            got_cyc [$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            stall_cnt = 0;
    int            stall_bad = 0;
    logic          prev_stall = 1'b0;
    logic [DW:0]   prev_word = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!coef_valid || {coef_last, coef_data} !== prev_word)) stall_bad++;
            if (coef_valid && coef_ready) begin
                got.push_back({coef_last, coef_data});
                got_cyc.push_back(cyc);
            end
            if (coef_valid && !coef_ready) stall_cnt++;
            prev_stall = coef_valid && !coef_ready;
            prev_word  = {coef_last, coef_data};
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    logic [DW-1:0] exp_mem [NW];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        next_cycle();
        frame_start = 1'b0;
    endtask

    // Engine model: consume n_px pixels, write f(pixel) to address k, then raise end flag.
    task automatic engine_run(input int n_px, input logic [DW-1:0] seed, input int uf_at);
        int guard = 0;
        while (wt_rst_n !== 1'b1 && guard < 20) begin
            next_cycle();
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++;
            $display("FAIL engine_wait: wt_rst_n=%0b after %0d cycles, required 1", wt_rst_n, guard);
        end
        for (int k = 0; k < n_px; k++) begin
            src_valid        = !(k >= uf_at && k < uf_at + 3);
            src_data         = DW'(k) + seed;
            wt_data_in_ready = 1'b1;
            wt_ram_address   = AW'(k);
            wt_ram_wren      = 1'b1;
            #1;
            if (src_ready !== 1'b1 || wt_data_input !== src_data) pass_bad++;
            wt_ram_data = wt_data_input ^ 16'h5A5A;
            exp_mem[k]  = (DW'(k) + seed) ^ 16'h5A5A;
            next_cycle();
        end
        wt_data_in_ready = 1'b0;
        wt_ram_wren      = 1'b0;
        src_valid        = 1'b0;
        wt_end_flag      = 1'b1;
        end_cyc          = cyc;
        next_cycle();
        wt_end_flag      = 1'b0;
    endtask

    // Runs the drain phase until frame_done, stop_at words, or the cycle budget.
    task automatic drain(input int budget, input bit bp, input bit poke_done, input int stop_at);
        int d0 = done_cnt;
        int n0 = got.size();
        int i;
        for (i = 0; i < budget; i++) begin
            coef_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            frame_start = poke_done && frame_done;
            if (stop_at > 0 && got.size() - n0 >= stop_at) break;
            if (done_cnt != d0) break;
            next_cycle();
        end
        frame_start = 1'b0;
        coef_ready  = 1'b1;
        checks++;
        if (i >= budget) begin
            errors++;
            $display("FAIL drain_timeout: no completion within %0d cycles, words=%0d", budget, got.size() - n0);
        end
    endtask

    function automatic int seq_bad(input int n0);
        int bad = 0;
        for (int k = 0; k < NW; k++) begin
            if (n0 + k >= got.size()) bad++;
            else if (got[n0 + k] !== {(k == NW - 1), exp_mem[k]}) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        wt_data_in_ready = 1'b1;
        src_data         = 16'hBEEF;
        wt_ram_address   = 12'h123;
        wt_ram_data      = 16'h4567;
        wt_ram_wren      = 1'b1;
        rst_n            = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if ({busy, frame_done, underrun, src_ready, wt_rst_n, coef_valid, coef_last, ram_wren} !== 8'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000000",
                     {busy, frame_done, underrun, src_ready, wt_rst_n, coef_valid, coef_last, ram_wren});
        end
        checks++;
        if ({ram_address, ram_data, wt_data_input, coef_data} !== '0) begin
            errors++;
            $display("FAIL reset_buses: addr=%h data=%h wt_in=%h coef=%h required 0",
                     ram_address, ram_data, wt_data_input, coef_data);
        end
        rst_n = 1'b1;
        repeat (2) next_cycle();
        @(negedge clk);
        checks++;
        if ({busy, underrun, src_ready, ram_wren} !== 4'b0 || ram_address !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%0b underrun=%0b src_ready=%0b wren=%0b addr=%h required all 0",
                     busy, underrun, src_ready, ram_wren, ram_address);
        end
        $display("test_reset done: errors=%0d", errors);
    endtask

    task automatic test_clear_timing();
        int s;
        next_cycle();
        wt_data_in_ready = 1'b1;
        src_valid        = 1'b1;
        src_data         = 16'h1111;
        wt_ram_address   = 12'h0AB;
        wt_ram_data      = 16'h2222;
        wt_ram_wren      = 1'b1;
        frame_start      = 1'b1;
        s = cyc;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_busy_t0: got %0b required 0 at cycle %0d", busy, s);
        end
        next_cycle();
        frame_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (wt_rst_n !== (i == 4) || busy !== 1'b1) begin
                errors++;
                $display("FAIL clear_wt_rst_n: cycle s+%0d wt_rst_n=%0b busy=%0b required %0b/1",
                         i, wt_rst_n, busy, (i == 4));
            end
            if (i < 4) begin
                checks++;
                if (src_ready !== 1'b0 || wt_data_input !== '0 || ram_wren !== 1'b0 || ram_address !== '0) begin
                    errors++;
                    $display("FAIL clear_gating: src_ready=%0b wt_in=%h wren=%0b addr=%h required 0",
                             src_ready, wt_data_input, ram_wren, ram_address);
                end
                next_cycle();
            end
        end
        checks++;
        if (src_ready !== 1'b1 || wt_data_input !== 16'h1111 || ram_address !== 12'h0AB || ram_data !== 16'h2222) begin
            errors++;
            $display("FAIL transform_mux: src_ready=%0b wt_in=%h addr=%h data=%h required 1/1111/0ab/2222",
                     src_ready, wt_data_input, ram_address, ram_data);
        end
        wt_data_in_ready = 1'b0;
        wt_ram_wren      = 1'b0;
        src_valid        = 1'b0;
        next_cycle();
        $display("test_clear_timing done: errors=%0d", errors);
    endtask

    task automatic test_nominal();
        int n0 = got.size();
        int d0 = done_cnt;
        int pb0 = pass_bad;
        int bad;
        engine_run(NW, 16'h0000, NW + 10);
        drain(4300, 1'b0, 1'b0, 0);
        @(negedge clk);
        checks++;
        if (pass_bad - pb0 != 0) begin
            errors++;
            $display("FAIL nominal_passthrough: %0d bad pixel cycles, required 0", pass_bad - pb0);
        end
        checks++;
        if (got.size() - n0 != NW) begin
            errors++;
            $display("FAIL nominal_count: got %0d words required %0d", got.size() - n0, NW);
        end
        bad = seq_bad(n0);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL nominal_sequence: %0d wrong words required 0", bad);
        end
        checks++;
        if (got_cyc.size() <= n0 || got_cyc[n0] != end_cyc + 3) begin
            errors++;
            $display("FAIL nominal_first_valid: got cycle %0d required %0d",
                     (got_cyc.size() > n0) ? got_cyc[n0] : -1, end_cyc + 3);
        end
        checks++;
        if (done_cyc != end_cyc + 1 + 4098 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL nominal_frame_done: cycle %0d count %0d required cycle %0d count 1",
                     done_cyc, done_cnt - d0, end_cyc + 1 + 4098);
        end
        checks++;
        if (underrun !== 1'b0 || busy !== 1'b0 || wt_ram_qout !== ram_q) begin
            errors++;
            $display("FAIL nominal_end_state: underrun=%0b busy=%0b qout=%h ram_q=%h required 0/0/equal",
                     underrun, busy, wt_ram_qout, ram_q);
        end
        next_cycle();
        $display("test_nominal done: errors=%0d", errors);
    endtask

    task automatic test_backpressure();
        int n0, d0, s0, sb0, bad;
        start_frame();
        engine_run(NW, 16'h1234, NW + 10);
        n0 = got.size(); d0 = done_cnt; s0 = stall_cnt; sb0 = stall_bad;
        drain(16000, 1'b1, 1'b0, 0);
        @(negedge clk);
        checks++;
        if (got.size() - n0 != NW) begin
            errors++;
            $display("FAIL bp_count: got %0d words required %0d", got.size() - n0, NW);
        end
        bad = seq_bad(n0);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_sequence: %0d wrong words required 0", bad);
        end
        checks++;
        if (stall_bad - sb0 != 0) begin
            errors++;
            $display("FAIL bp_stable: %0d unstable stall cycles required 0", stall_bad - sb0);
        end
        checks++;
        if (stall_cnt - s0 < 100 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL bp_activity: stalls=%0d done=%0d required >=100 stalls and 1 done",
                     stall_cnt - s0, done_cnt - d0);
        end
        next_cycle();
        $display("test_backpressure done: errors=%0d", errors);
    endtask

    task automatic test_underrun();
        int n0, bad;
        start_frame();
        engine_run(16, 16'h0777, 5);
        @(negedge clk);
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_set: got %0b required 1", underrun);
        end
        next_cycle();
        n0 = got.size();
        drain(4300, 1'b0, 1'b0, 0);
        repeat (2) next_cycle();
        @(negedge clk);
        checks++;
        if (underrun !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL underrun_sticky: underrun=%0b busy=%0b required 1/0", underrun, busy);
        end
        bad = seq_bad(n0);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL underrun_sequence: %0d wrong words required 0", bad);
        end
        next_cycle();
        $display("test_underrun done: errors=%0d", errors);
    endtask

    task automatic test_start_while_busy();
        int d0;
        start_frame();
        @(negedge clk);
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clear: got %0b required 0", underrun);
        end
        repeat (3) next_cycle();
        frame_start = 1'b1;
        next_cycle();
        frame_start = 1'b0;
        @(negedge clk);
        checks++;
        if (wt_rst_n !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_in_transform: wt_rst_n=%0b busy=%0b required 1/1", wt_rst_n, busy);
        end
        next_cycle();
        engine_run(8, 16'h0042, NW + 10);
        d0 = done_cnt;
        drain(4300, 1'b0, 1'b1, 0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: busy=%0b after DONE-cycle start, required 0", busy);
        end
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_done_count: frame_done pulses=%0d busy=%0b required 1/0", done_cnt - d0, busy);
        end
        next_cycle();
        $display("test_start_while_busy done: errors=%0d", errors);
    endtask

    task automatic test_reset_mid_drain();
        int n0, d0, bad;
        start_frame();
        engine_run(32, 16'h0900, NW + 10);
        n0 = got.size(); d0 = done_cnt;
        drain(4300, 1'b0, 1'b0, 100);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, frame_done, underrun, src_ready, wt_rst_n, coef_valid, coef_last, ram_wren} !== 8'b0
            || ram_address !== '0 || coef_data !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: flags=%b addr=%h coef=%h required 0",
                     {busy, frame_done, underrun, src_ready, wt_rst_n, coef_valid, coef_last, ram_wren},
                     ram_address, coef_data);
        end
        checks++;
        if (got.size() - n0 != 100) begin
            errors++;
            $display("FAIL midreset_words: got %0d words before reset required 100", got.size() - n0);
        end
        repeat (2) next_cycle();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL midreset_no_done: frame_done pulses=%0d required 0", done_cnt - d0);
        end
        start_frame();
        engine_run(4, 16'h0C00, NW + 10);
        n0 = got.size(); d0 = done_cnt;
        drain(4300, 1'b0, 1'b0, 0);
        @(negedge clk);
        checks++;
        if (got.size() - n0 != NW || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL midreset_next_count: words=%0d done=%0d required %0d/1", got.size() - n0, done_cnt - d0, NW);
        end
        bad = seq_bad(n0);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_next_sequence: %0d wrong words required 0", bad);
        end
        $display("test_reset_mid_drain done: errors=%0d", errors);
    endtask

    initial begin
        test_reset();
        test_clear_timing();
        test_nominal();
        test_backpressure();
        test_underrun();
        test_start_while_busy();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
